// File: rtl/vga_frame_capture_if.sv
// vga_frame_capture_if: video input, capture control and
// frame-buffer write port of the VGA frame grabber.
interface vga_frame_capture_if #(
  parameter int ADDR_W = 19
);
  logic              pixel_en;
  logic              h_sync;
  logic              v_sync;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  logic              start;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              frame_done;
  logic              sync_err;

  modport master (
    output pixel_en, h_sync, v_sync,
    output red, green, blue, start,
    input  busy, wr_en, wr_addr, wr_data,
    input  frame_done, sync_err
  );

  modport slave (
    input  pixel_en, h_sync, v_sync,
    input  red, green, blue, start,
    output busy, wr_en, wr_addr, wr_data,
    output frame_done, sync_err
  );
endinterface

// File: rtl/vga_frame_capture.sv
// vga_frame_capture: recovers raster position from VGA syncs and
// writes one armed, complete frame to a frame-buffer write port.
module vga_frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19
) (
  input logic clk,
  input logic reset,
  vga_frame_capture_if.slave bus
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;
  localparam int H_FIRST = H_SYNC + H_BP;
  localparam int H_LAST  = H_FIRST + H_ACTIVE - 1;
  localparam int V_FIRST = V_SYNC + V_BP;
  localparam int V_LAST  = V_FIRST + V_ACTIVE - 1;
  localparam logic [31:0] LAST_ADDR =
    32'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [HW-1:0] H_MAX = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_MAX = VW'(V_TOTAL - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]        state;
  logic [HW-1:0]     hCnt;
  logic [HW-1:0]     hNext;
  logic [VW-1:0]     vCnt;
  logic [VW-1:0]     vNext;
  logic              hPrev;
  logic              vPrev;
  logic              hFall;
  logic              vFall;
  logic              hErr;
  logic              active;
  logic [31:0]       col;
  logic [31:0]       line;
  logic [31:0]       addr;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [23:0]       wrData;
  logic              frameDone;
  logic              syncErr;

  // Position is evaluated on the post-update counts of this pixel.
  always_comb begin
    hFall = hPrev & ~bus.h_sync;
    vFall = vPrev & ~bus.v_sync;
    hErr  = hFall && (hCnt != H_MAX);
    hNext = hCnt;
    vNext = vCnt;
    if (hFall)
      hNext = '0;
    else if (hCnt != H_MAX)
      hNext = hCnt + HW'(1);
    if (vFall)
      vNext = '0;
    else if (hFall && (vCnt != V_MAX))
      vNext = vCnt + VW'(1);
    active = (32'(hNext) >= 32'(H_FIRST))
          && (32'(hNext) <= 32'(H_LAST))
          && (32'(vNext) >= 32'(V_FIRST))
          && (32'(vNext) <= 32'(V_LAST));
    col  = 32'(hNext) - 32'(H_FIRST);
    line = 32'(vNext) - 32'(V_FIRST);
    addr = line * 32'(H_ACTIVE) + col;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hCnt      <= '0;
      vCnt      <= '0;
      hPrev     <= 1'b1;
      vPrev     <= 1'b1;
      wrEn      <= 1'b0;
      wrAddr    <= '0;
      wrData    <= '0;
      frameDone <= 1'b0;
      syncErr   <= 1'b0;
    end else begin
      wrEn      <= 1'b0;
      frameDone <= 1'b0;
      if (bus.pixel_en) begin
        hPrev <= bus.h_sync;
        vPrev <= bus.v_sync;
        hCnt  <= hNext;
        vCnt  <= vNext;
      end
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= ARMED;
            syncErr <= 1'b0;
          end
        end
        ARMED: begin
          if (bus.pixel_en && vFall)
            state <= CAPTURE;
        end
        CAPTURE: begin
          if (bus.pixel_en) begin
            // A vsync edge inside the frame means it was cut short.
            if (vFall) begin
              syncErr <= 1'b1;
              state   <= IDLE;
            end else begin
              if (hErr)
                syncErr <= 1'b1;
              if (active) begin
                wrEn   <= 1'b1;
                wrAddr <= addr[ADDR_W-1:0];
                wrData <= {bus.red, bus.green, bus.blue};
                if (addr == LAST_ADDR)
                  state <= DONE;
              end
            end
          end
        end
        DONE: begin
          frameDone <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.wr_en      = wrEn;
  assign bus.wr_addr    = wrAddr;
  assign bus.wr_data    = wrData;
  assign bus.frame_done = frameDone;
  assign bus.sync_err   = syncErr;
endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: directed frames on a scaled 8x6 raster
// (4x3 active) with an address/data scoreboard of all writes.
module tb_vga_frame_capture;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_frame_capture_if #(.ADDR_W(4)) vif();

  vga_frame_capture #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .ADDR_W(4)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(vif.slave)
  );

  int errs = 0;
  int checks = 0;

  logic [3:0]  wrA[$];
  logic [23:0] wrD[$];
  int nDone = 0;
  int doneDly = -1;
  int badPe = 0;
  int cyc = 0;
  int lastWrCyc = 0;
  logic peLast = 1'b0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    peLast <= vif.pixel_en;
  end

  always @(negedge clk) begin
    if (vif.wr_en) begin
      wrA.push_back(vif.wr_addr);
      wrD.push_back(vif.wr_data);
      lastWrCyc = cyc;
      if (!peLast) badPe++;
    end
    if (vif.frame_done) begin
      nDone++;
      doneDly = cyc - lastWrCyc;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic clrMon();
    wrA.delete();
    wrD.delete();
    nDone = 0;
    doneDly = -1;
    badPe = 0;
  endtask

  task automatic drivePix(input logic hs, input logic vs,
                          input logic [23:0] d,
                          input logic st, input int gap);
    vif.pixel_en = 1'b1;
    vif.h_sync = hs;
    vif.v_sync = vs;
    {vif.red, vif.green, vif.blue} = d;
    vif.start = st;
    @(posedge clk); #1;
    vif.start = 1'b0;
    vif.pixel_en = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulseStart();
    vif.pixel_en = 1'b0;
    vif.start = 1'b1;
    @(posedge clk); #1;
    vif.start = 1'b0;
  endtask

  // One raster: hsync low for h<2, vsync low on line 0.
  task automatic sendFrame(input int gap, input int startLine,
                           input int shortLine,
                           input int stopV, input int stopH);
    logic [23:0] d;
    logic act;
    for (int v = 0; v < 6; v++) begin
      for (int h = 0; h < 8; h++) begin
        if (v == shortLine && h >= 6) continue;
        act = (h >= 3 && h <= 6 && v >= 2 && v <= 4);
        d = act ? {8'(v - 2), 8'(h - 3), 8'hA5} : 24'h0;
        drivePix(h >= 2, v >= 1, d,
                 (v == startLine && h == 0), gap);
        if (v == stopV && h == stopH) return;
      end
    end
  endtask

  task automatic chkWrites(input string tag,
                           input int nExp, input int skip);
    logic [23:0] e;
    int idx;
    chk({tag, "_count"}, wrA.size(), nExp);
    idx = 0;
    for (int a = 0; a < 12; a++) begin
      if (a == skip) continue;
      if (idx >= nExp || idx >= wrA.size()) break;
      e = {8'(a / 4), 8'(a % 4), 8'hA5};
      chk($sformatf("%s_addr%0d", tag, idx), wrA[idx], a);
      chk($sformatf("%s_data%0d", tag, idx), wrD[idx], e);
      idx++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    vif.pixel_en = 1'b0;
    vif.h_sync = 1'b1;
    vif.v_sync = 1'b1;
    {vif.red, vif.green, vif.blue} = 24'h0;
    vif.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", vif.busy, 0);
    chk("rst_wr_en", vif.wr_en, 0);
    chk("rst_wr_addr", vif.wr_addr, 0);
    chk("rst_wr_data", vif.wr_data, 0);
    chk("rst_done", vif.frame_done, 0);
    chk("rst_err", vif.sync_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two clean frames, only the first is captured.
    clrMon();
    pulseStart();
    chk("t1_busy", vif.busy, 1);
    sendFrame(0, -1, -1, -1, -1);
    chkWrites("t1", 12, -1);
    chk("t1_addr5_data", wrD.size() > 5 ? wrD[5] : 0,
        24'h0101A5);
    chk("t1_done", nDone, 1);
    chk("t1_done_dly", doneDly, 1);
    chk("t1_busy_end", vif.busy, 0);
    chk("t1_err", vif.sync_err, 0);
    sendFrame(0, -1, -1, -1, -1);
    chk("t1_frame2_count", wrA.size(), 12);
    chk("t1_frame2_done", nDone, 1);

    // Pixel enable on every other cycle.
    clrMon();
    pulseStart();
    sendFrame(1, -1, -1, -1, -1);
    chkWrites("t2", 12, -1);
    chk("t2_done", nDone, 1);
    chk("t2_done_dly", doneDly, 1);
    chk("t2_pe_gate", badPe, 0);
    chk("t2_busy_end", vif.busy, 0);

    // Start arrives mid-frame: that frame is skipped.
    clrMon();
    sendFrame(0, 3, -1, -1, -1);
    chk("t3_partial", wrA.size(), 0);
    chk("t3_busy", vif.busy, 1);
    sendFrame(0, -1, -1, -1, -1);
    chkWrites("t3", 12, -1);
    chk("t3_done", nDone, 1);

    // Short active line 1: column 3 (addr 7) never sent.
    clrMon();
    pulseStart();
    sendFrame(0, -1, 3, -1, -1);
    chkWrites("t4", 11, 7);
    chk("t4_err", vif.sync_err, 1);
    chk("t4_done", nDone, 1);
    chk("t4_busy_end", vif.busy, 0);
    sendFrame(0, -1, -1, -1, -1);
    chk("t4_err_sticky", vif.sync_err, 1);
    pulseStart();
    chk("t4_err_clr", vif.sync_err, 0);
    chk("t4_rearm", vif.busy, 1);

    // Vsync falls where active line 2 should begin.
    clrMon();
    sendFrame(0, -1, -1, 3, 7);
    sendFrame(0, -1, -1, -1, -1);
    chkWrites("t5", 8, -1);
    chk("t5_err", vif.sync_err, 1);
    chk("t5_busy", vif.busy, 0);
    chk("t5_done", nDone, 0);

    // Reset right after the addr 6 write.
    clrMon();
    pulseStart();
    sendFrame(0, -1, -1, 3, 5);
    @(negedge clk); #1;
    chk("t6_pre_count", wrA.size(), 7);
    chk("t6_pre_last", wrA.size() > 0 ? wrA[$] : 4'hF, 6);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", vif.busy, 0);
    chk("t6_wr_en", vif.wr_en, 0);
    chk("t6_wr_addr", vif.wr_addr, 0);
    chk("t6_wr_data", vif.wr_data, 0);
    chk("t6_done", vif.frame_done, 0);
    chk("t6_err", vif.sync_err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clrMon();
    sendFrame(0, -1, -1, -1, -1);
    chk("t6_nostart_count", wrA.size(), 0);
    chk("t6_nostart_busy", vif.busy, 0);
    chk("t6_nostart_done", nDone, 0);
    pulseStart();
    sendFrame(0, -1, -1, -1, -1);
    chkWrites("t6_recap", 12, -1);
    chk("t6_recap_done", nDone, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
